// File: rtl/multiplexer_16bit_sync_if.sv
// Bus bundle for the registered 16:1 word multiplexer.
// out_par is present only when MUX_PARITY_EN is defined.
interface multiplexer_16bit_sync_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4
);
  logic [DATA_W-1:0] I0;
  logic [DATA_W-1:0] I1;
  logic [DATA_W-1:0] I2;
  logic [DATA_W-1:0] I3;
  logic [DATA_W-1:0] I4;
  logic [DATA_W-1:0] I5;
  logic [DATA_W-1:0] I6;
  logic [DATA_W-1:0] I7;
  logic [DATA_W-1:0] I8;
  logic [DATA_W-1:0] I9;
  logic [DATA_W-1:0] I10;
  logic [DATA_W-1:0] I11;
  logic [DATA_W-1:0] I12;
  logic [DATA_W-1:0] I13;
  logic [DATA_W-1:0] I14;
  logic [DATA_W-1:0] I15;
  logic [SEL_W-1:0]  s;
  logic              in_valid;
  logic [DATA_W-1:0] out;
  logic              out_valid;
`ifdef MUX_PARITY_EN
  logic              out_par;
`endif

  modport master (
    output I0, I1, I2, I3, I4, I5, I6, I7,
    output I8, I9, I10, I11, I12, I13, I14, I15,
    output s, in_valid,
`ifdef MUX_PARITY_EN
    input  out_par,
`endif
    input  out, out_valid
  );

  modport slave (
    input  I0, I1, I2, I3, I4, I5, I6, I7,
    input  I8, I9, I10, I11, I12, I13, I14, I15,
    input  s, in_valid,
`ifdef MUX_PARITY_EN
    output out_par,
`endif
    output out, out_valid
  );
endinterface

// File: rtl/multiplexer_16bit_sync.sv
// Registered 16:1 word multiplexer: selected word is re-timed to clk with 1-cycle latency.
// Optional even-parity output out_par is enabled by defining MUX_PARITY_EN.
module multiplexer_16bit_sync #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multiplexer_16bit_sync_if.slave   bus
);

  // XOR-reduction of a data word; 1 when the word holds an odd number of ones.
  function automatic logic parity_f(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

  logic [DATA_W-1:0] sel_word_s;
  logic [DATA_W-1:0] out_r;
  logic              out_valid_r;
`ifdef MUX_PARITY_EN
  logic              out_par_r;
`endif

  // Select decode: every code maps to a defined input, so no X can reach the register.
  always_comb begin
    sel_word_s = bus.I0;
    case (bus.s)
      4'b0000: sel_word_s = bus.I0;
      4'b0001: sel_word_s = bus.I1;
      4'b0010: sel_word_s = bus.I2;
      4'b0011: sel_word_s = bus.I3;
      4'b0100: sel_word_s = bus.I4;
      4'b0101: sel_word_s = bus.I5;
      4'b0110: sel_word_s = bus.I6;
      4'b0111: sel_word_s = bus.I7;
      4'b1000: sel_word_s = bus.I8;
      4'b1001: sel_word_s = bus.I9;
      4'b1010: sel_word_s = bus.I10;
      4'b1011: sel_word_s = bus.I11;
      4'b1100: sel_word_s = bus.I12;
      4'b1101: sel_word_s = bus.I13;
      4'b1110: sel_word_s = bus.I14;
      4'b1111: sel_word_s = bus.I15;
      default: sel_word_s = bus.I0;
    endcase
  end

  // Capture register: word and valid update on in_valid; word holds otherwise, valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r       <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (bus.in_valid) begin
      out_r       <= sel_word_s;
      out_valid_r <= 1'b1;
    end else begin
      out_r       <= out_r;
      out_valid_r <= 1'b0;
    end
  end

`ifdef MUX_PARITY_EN
  // Parity register: loaded alongside out_r so it always describes the word on out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_par_r <= 1'b0;
    end else if (bus.in_valid) begin
      out_par_r <= parity_f(sel_word_s);
    end else begin
      out_par_r <= out_par_r;
    end
  end

  assign bus.out_par   = out_par_r;
`endif

  assign bus.out       = out_r;
  assign bus.out_valid = out_valid_r;

endmodule

// File: tb/tb_multiplexer_16bit_sync.sv
// Directed, table-driven bench for multiplexer_16bit_sync (parity checks when MUX_PARITY_EN is defined).
module tb_multiplexer_16bit_sync;

  typedef struct {
    logic [3:0]  s;
    logic        in_valid;
    logic [15:0] exp_out;
    logic        exp_valid;
  } vec_t;

  logic clk;
  logic rst_n;
  logic [15:0] d [16];
  int pass_cnt;
  int total_cnt;
  vec_t vecs [$];

  multiplexer_16bit_sync_if #(.DATA_W(16), .SEL_W(4)) bus ();

  multiplexer_16bit_sync #(.DATA_W(16), .SEL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.I0  = d[0];
  assign bus.I1  = d[1];
  assign bus.I2  = d[2];
  assign bus.I3  = d[3];
  assign bus.I4  = d[4];
  assign bus.I5  = d[5];
  assign bus.I6  = d[6];
  assign bus.I7  = d[7];
  assign bus.I8  = d[8];
  assign bus.I9  = d[9];
  assign bus.I10 = d[10];
  assign bus.I11 = d[11];
  assign bus.I12 = d[12];
  assign bus.I13 = d[13];
  assign bus.I14 = d[14];
  assign bus.I15 = d[15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_out(input string name, input logic [15:0] exp_out, input logic exp_valid);
    check({name, ".out"}, {16'h0000, bus.out}, {16'h0000, exp_out});
    check({name, ".valid"}, {31'h0, bus.out_valid}, {31'h0, exp_valid});
`ifdef MUX_PARITY_EN
    check({name, ".par"}, {31'h0, bus.out_par}, {31'h0, ^exp_out});
`endif
  endtask

  task automatic load_defaults();
    d[0]  = 16'hAAAA; d[1]  = 16'hBBBB; d[2]  = 16'hCCCC; d[3]  = 16'hDDDD;
    d[4]  = 16'hEEEE; d[5]  = 16'hFFFF; d[6]  = 16'h1234; d[7]  = 16'h5678;
    d[8]  = 16'h9ABC; d[9]  = 16'hDEF0; d[10] = 16'h1111; d[11] = 16'h2222;
    d[12] = 16'h3333; d[13] = 16'h4444; d[14] = 16'h5555; d[15] = 16'h6666;
  endtask

  // Apply inputs, then sample 1 time unit after the next rising edge.
  task automatic step(input logic [3:0] sel, input logic vld);
    bus.s = sel;
    bus.in_valid = vld;
    @(posedge clk);
    #1;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    bus.s = 4'd0;
    bus.in_valid = 1'b0;
    load_defaults();

    // Sweep, then hold sequence; expected words are the literal input constants.
    vecs.push_back('{s: 4'd0,  in_valid: 1'b1, exp_out: 16'hAAAA, exp_valid: 1'b1});
    vecs.push_back('{s: 4'd1,  in_valid: 1'b1, exp_out: 16'hBBBB, exp_valid: 1'b1});
    vecs.push_back('{s: 4'd2,  in_valid: 1'b1, exp_out: 16'hCCCC, exp_valid: 1'b1});
    vecs.push_back('{s: 4'd3,  in_valid: 1'b1, exp_out: 16'hDDDD, exp_valid: 1'b1});
    vecs.push_back('{s: 4'd4,  in_valid: 1'b1, exp_out: 16'hEEEE, exp_valid: 1'b1});
    vecs.push_back('{s: 4'd5,  in_valid: 1'b1, exp_out: 16'hFFFF, exp_valid: 1'b1});
    vecs.push_back('{s: 4'd6,  in_valid: 1'b1, exp_out: 16'h1234, exp_valid: 1'b1});
    vecs.push_back('{s: 4'd7,  in_valid: 1'b1, exp_out: 16'h5678, exp_valid: 1'b1});
    vecs.push_back('{s: 4'd8,  in_valid: 1'b1, exp_out: 16'h9ABC, exp_valid: 1'b1});
    vecs.push_back('{s: 4'd9,  in_valid: 1'b1, exp_out: 16'hDEF0, exp_valid: 1'b1});
    vecs.push_back('{s: 4'd10, in_valid: 1'b1, exp_out: 16'h1111, exp_valid: 1'b1});
    vecs.push_back('{s: 4'd11, in_valid: 1'b1, exp_out: 16'h2222, exp_valid: 1'b1});
    vecs.push_back('{s: 4'd12, in_valid: 1'b1, exp_out: 16'h3333, exp_valid: 1'b1});
    vecs.push_back('{s: 4'd13, in_valid: 1'b1, exp_out: 16'h4444, exp_valid: 1'b1});
    vecs.push_back('{s: 4'd14, in_valid: 1'b1, exp_out: 16'h5555, exp_valid: 1'b1});
    vecs.push_back('{s: 4'd15, in_valid: 1'b1, exp_out: 16'h6666, exp_valid: 1'b1});
    vecs.push_back('{s: 4'd8,  in_valid: 1'b1, exp_out: 16'h9ABC, exp_valid: 1'b1});
    vecs.push_back('{s: 4'd1,  in_valid: 1'b0, exp_out: 16'h9ABC, exp_valid: 1'b0});
    vecs.push_back('{s: 4'd15, in_valid: 1'b0, exp_out: 16'h9ABC, exp_valid: 1'b0});
    vecs.push_back('{s: 4'd3,  in_valid: 1'b1, exp_out: 16'hDDDD, exp_valid: 1'b1});

    // Reset held with toggling inputs.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 16; k++) d[k] = 16'($urandom);
      step(4'($urandom_range(0, 15)), 1'b1);
      check_out($sformatf("reset_hold%0d", i), 16'h0000, 1'b0);
    end
    load_defaults();

    // Release at a falling edge: the first rising edge captures.
    @(negedge clk);
    rst_n = 1'b1;
    step(4'd3, 1'b1);
    check_out("first_capture", 16'hDDDD, 1'b1);

    // Asynchronous clear between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_clear", 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].s, vecs[i].in_valid);
      check_out($sformatf("vec%0d_s%0d", i, vecs[i].s), vecs[i].exp_out, vecs[i].exp_valid);
    end

    // Data change under fixed select; other inputs are ignored.
    step(4'd5, 1'b1);
    check_out("sel5_ffff", 16'hFFFF, 1'b1);
    d[5] = 16'h0F0F;
    step(4'd5, 1'b1);
    check_out("sel5_0f0f", 16'h0F0F, 1'b1);
    d[4] = 16'h0000;
    d[6] = 16'hBEEF;
    step(4'd5, 1'b1);
    check_out("sel5_others", 16'h0F0F, 1'b1);
    load_defaults();

    // Select and data changing together: values at the edge win.
    bus.s = 4'd2;
    d[9] = 16'hC0DE;
    step(4'd9, 1'b1);
    check_out("sel_and_data", 16'hC0DE, 1'b1);
    load_defaults();

    // Reset mid-sweep discards the in-flight selection.
    step(4'd0, 1'b1);
    check_out("mid_s0", 16'hAAAA, 1'b1);
    step(4'd1, 1'b1);
    check_out("mid_s1", 16'hBBBB, 1'b1);
    bus.s = 4'd2;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("mid_clear", 16'h0000, 1'b0);
    step(4'd2, 1'b1);
    check_out("mid_held", 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'd7, 1'b1);
    check_out("mid_resume", 16'h5678, 1'b1);
    step(4'd8, 1'b1);
    check_out("mid_resume2", 16'h9ABC, 1'b1);

`ifdef MUX_PARITY_EN
    step(4'd6, 1'b1);
    check("par_1234", {31'h0, bus.out_par}, 32'd1);
    step(4'd0, 1'b1);
    check("par_aaaa", {31'h0, bus.out_par}, 32'd0);
    step(4'd6, 1'b0);
    check("par_hold", {31'h0, bus.out_par}, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
